// File: rtl/mem_lsu_pkg.sv
// Shared opcodes, funct3 codes, FSM states and the alignment check for the mem_lsu stage.
`default_nettype none

package mem_lsu_pkg;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } lsu_state_e;

  // Undefined encodings (funct3 111, or unsigned forms on a store) are reported as misaligned.
  function automatic logic access_ok(input logic is_store, input logic [2:0] funct3,
                                     input logic [2:0] offset);
    logic ok;
    ok = 1'b0;
    if (funct3 != 3'b111 && !(is_store && funct3[2])) begin
      case (funct3[1:0])
        2'b00:   ok = 1'b1;
        2'b01:   ok = (offset[0] == 1'b0);
        2'b10:   ok = (offset[1:0] == 2'b00);
        default: ok = (offset == 3'b000);
      endcase
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lsu_align.sv
// Byte-lane steering: store mask/data shift and load extract with sign/zero extension.
`default_nettype none

module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      st_size,
  input  logic [2:0]      st_offset,
  input  logic [XLEN-1:0] st_data,
  output logic [7:0]      st_wmask,
  output logic [XLEN-1:0] st_wdata,
  input  logic [2:0]      ld_funct3,
  input  logic [2:0]      ld_offset,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_result
);

  logic [7:0]      base_mask;
  logic [XLEN-1:0] ld_shifted;

  always_comb begin
    base_mask = 8'h01;
    case (st_size)
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      2'b10:   base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
    st_wmask = base_mask << st_offset;
    st_wdata = st_data << {st_offset, 3'b000};
  end

  always_comb begin
    ld_shifted = ld_rdata >> {ld_offset, 3'b000};
    ld_result  = '0;
    case (ld_funct3)
      F3_B:    ld_result = {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
      F3_H:    ld_result = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
      F3_W:    ld_result = {{(XLEN-32){ld_shifted[31]}}, ld_shifted[31:0]};
      F3_D:    ld_result = ld_shifted;
      F3_BU:   ld_result = {{(XLEN-8){1'b0}}, ld_shifted[7:0]};
      F3_HU:   ld_result = {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
      F3_WU:   ld_result = {{(XLEN-32){1'b0}}, ld_shifted[31:0]};
      default: ld_result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// Memory-access pipeline stage: req/ack data-memory port, registered writeback and EX forwarding.
`default_nettype none

module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            wreg_i,
  input  logic [11:0]     csr_waddr_i,
  input  logic            csr_wreg_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [AW-1:0]   dmem_addr_o,
  output logic [7:0]      dmem_wmask_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_ack_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            out_valid_o,
  output logic [4:0]      wb_rd_addr_o,
  output logic            wb_wreg_o,
  output logic [XLEN-1:0] wb_wdata_o,
  output logic [11:0]     wb_csr_waddr_o,
  output logic            wb_csr_wreg_o,
  output logic [XLEN-1:0] wb_csr_wdata_o,
  output logic            misalign_o,
  output logic [4:0]      mem_back_rd_addr_o,
  output logic            mem_back_wreg_o,
  output logic [XLEN-1:0] mem_back_wdata_o,
  output logic [11:0]     mem_back_csr_waddr_o,
  output logic            mem_back_csr_wreg_o,
  output logic [XLEN-1:0] mem_back_csr_wdata_o
);

  lsu_state_e state, state_next;

  logic [AW-1:0]   addr_q;
  logic [2:0]      funct3_q;
  logic            store_q;
  logic [7:0]      wmask_q;
  logic [XLEN-1:0] st_wdata_q;
  logic [4:0]      rd_q;
  logic            wreg_q;
  logic [11:0]     csr_waddr_q;
  logic            csr_wreg_q;
  logic [XLEN-1:0] csr_wdata_q;

  logic            accept, is_load, is_store, is_mem, aligned, start_bus, bus_done;
  logic [7:0]      st_wmask;
  logic [XLEN-1:0] st_wdata, ld_result;

  assign in_ready_o = (state == ST_IDLE);
  assign accept     = in_valid_i & in_ready_o;
  assign is_load    = (opcode_i == OPCODE_LOAD);
  assign is_store   = (opcode_i == OPCODE_STORE);
  assign is_mem     = is_load | is_store;
  assign aligned    = access_ok(is_store, funct3_i, wdata_i[2:0]);
  assign start_bus  = accept & is_mem & aligned;
  assign bus_done   = (state == ST_BUS) & dmem_req_o & dmem_ack_i;

  mem_lsu_align #(.XLEN(XLEN)) u_align (
    .st_size   (funct3_i[1:0]),
    .st_offset (wdata_i[2:0]),
    .st_data   (store_data_i),
    .st_wmask  (st_wmask),
    .st_wdata  (st_wdata),
    .ld_funct3 (funct3_q),
    .ld_offset (addr_q[2:0]),
    .ld_rdata  (dmem_rdata_i),
    .ld_result (ld_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_bus) state_next = ST_BUS;
      ST_BUS:  if (bus_done)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request attributes are frozen at accept so the bus sees them stable until ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req_o  <= 1'b0;
      addr_q      <= '0;
      funct3_q    <= '0;
      store_q     <= 1'b0;
      wmask_q     <= '0;
      st_wdata_q  <= '0;
      rd_q        <= '0;
      wreg_q      <= 1'b0;
      csr_waddr_q <= '0;
      csr_wreg_q  <= 1'b0;
      csr_wdata_q <= '0;
    end else if (start_bus) begin
      dmem_req_o  <= 1'b1;
      addr_q      <= wdata_i[AW-1:0];
      funct3_q    <= funct3_i;
      store_q     <= is_store;
      wmask_q     <= is_store ? st_wmask : 8'h00;
      st_wdata_q  <= st_wdata;
      rd_q        <= rd_addr_i;
      wreg_q      <= wreg_i;
      csr_waddr_q <= csr_waddr_i;
      csr_wreg_q  <= csr_wreg_i;
      csr_wdata_q <= csr_wdata_i;
    end else if (bus_done) begin
      dmem_req_o  <= 1'b0;
    end
  end

  assign dmem_we_o    = store_q;
  assign dmem_addr_o  = {addr_q[AW-1:3], 3'b000};
  assign dmem_wmask_o = wmask_q;
  assign dmem_wdata_o = st_wdata_q;

  // Output slot: write enables and valid fall to 0 on any cycle without a new result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_o    <= 1'b0;
      misalign_o     <= 1'b0;
      wb_rd_addr_o   <= '0;
      wb_wreg_o      <= 1'b0;
      wb_wdata_o     <= '0;
      wb_csr_waddr_o <= '0;
      wb_csr_wreg_o  <= 1'b0;
      wb_csr_wdata_o <= '0;
    end else begin
      out_valid_o   <= 1'b0;
      misalign_o    <= 1'b0;
      wb_wreg_o     <= 1'b0;
      wb_csr_wreg_o <= 1'b0;
      if (accept && !start_bus) begin
        out_valid_o    <= 1'b1;
        misalign_o     <= is_mem;
        wb_rd_addr_o   <= rd_addr_i;
        wb_wreg_o      <= is_mem ? 1'b0 : wreg_i;
        wb_wdata_o     <= is_mem ? '0 : wdata_i;
        wb_csr_waddr_o <= csr_waddr_i;
        wb_csr_wreg_o  <= csr_wreg_i;
        wb_csr_wdata_o <= csr_wdata_i;
      end else if (bus_done) begin
        out_valid_o    <= 1'b1;
        wb_rd_addr_o   <= rd_q;
        wb_wreg_o      <= wreg_q & ~store_q;
        wb_wdata_o     <= store_q ? '0 : ld_result;
        wb_csr_waddr_o <= csr_waddr_q;
        wb_csr_wreg_o  <= csr_wreg_q;
        wb_csr_wdata_o <= csr_wdata_q;
      end
    end
  end

  assign mem_back_rd_addr_o   = wb_rd_addr_o;
  assign mem_back_wreg_o      = out_valid_o & wb_wreg_o;
  assign mem_back_wdata_o     = wb_wdata_o;
  assign mem_back_csr_waddr_o = wb_csr_waddr_o;
  assign mem_back_csr_wreg_o  = out_valid_o & wb_csr_wreg_o;
  assign mem_back_csr_wdata_o = wb_csr_wdata_o;

endmodule

`default_nettype wire
